// File: rtl/spi_fifo_apb.sv
// APB-programmable SPI master with TX/RX FIFOs, programmable CPOL/CPHA,
// SCK prescaler, chip-select decode and sticky interrupt status.
module spi_fifo_apb #(
    parameter int DW      = 8,
    parameter int FIFO_AW = 2,
    parameter int NUM_CS  = 2
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [31:0]       PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              IRQ,
    input  logic              MSI,
    output logic              MSO,
    output logic              SCK,
    output logic [NUM_CS-1:0] SSn
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int LW    = FIFO_AW + 1;
    localparam int EW    = $clog2(2 * DW);

    typedef enum logic [1:0] {IDLE, SHIFT, LAST} state_t;
    state_t state_q, state_d;

    logic [DW-1:0] tx_mem [DEPTH];
    logic [DW-1:0] rx_mem [DEPTH];
    logic [LW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [1:0]    cfg_q;
    logic          en_q, ss_q;
    logic [2:0]    cs_q;
    logic [7:0]    pre_q;
    logic [3:0]    im_q;
    logic          done_q, ovr_q, ovf_q;
    logic [7:0]    cnt_q, pre_l_q;
    logic [EW-1:0] edge_q;
    logic          sck_q, cpol_l_q, cpha_l_q;
    logic [DW-1:0] txsh_q, rxsh_q;

    logic          wr_en, rd_en;
    logic [5:0]    sel;
    logic [LW-1:0] tx_lvl, rx_lvl;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic          start, tx_push_req, tx_push, rx_pop, rx_push, in_last;
    logic          tick, edge_last, leading, ic_wr;
    logic [3:0]    ris;
    logic [31:0]   status;
    logic          unused_bits;

    assign PREADY      = 1'b1;
    assign wr_en       = PSEL & PENABLE & PWRITE;
    assign rd_en       = PSEL & PENABLE & ~PWRITE;
    assign sel         = PADDR[7:2];
    assign unused_bits = ^{PADDR[31:8], PADDR[1:0], PWDATA};

    assign tx_lvl   = tx_wp_q - tx_rp_q;
    assign rx_lvl   = rx_wp_q - rx_rp_q;
    assign tx_empty = (tx_lvl == '0);
    assign tx_full  = (tx_lvl == LW'(DEPTH));
    assign rx_empty = (rx_lvl == '0);
    assign rx_full  = (rx_lvl == LW'(DEPTH));

    // A full FIFO still accepts a push when the same cycle pops it.
    assign start       = (state_q == IDLE) & en_q & ~tx_empty;
    assign tx_push_req = wr_en & (sel == 6'h00);
    assign tx_push     = tx_push_req & (~tx_full | start);
    assign rx_pop      = rd_en & (sel == 6'h00) & ~rx_empty;
    assign in_last     = (state_q == LAST);
    assign rx_push     = in_last & (~rx_full | rx_pop);
    assign ic_wr       = wr_en & (sel == 6'h07);

    assign tick      = (cnt_q == pre_l_q);
    assign edge_last = (edge_q == EW'(2 * DW - 1));
    assign leading   = ~edge_q[0];

    assign ris = {ovf_q, tx_empty, ovr_q, done_q};
    assign IRQ = |(im_q & ris);
    assign SCK = (state_q == IDLE) ? cfg_q[0] : sck_q;
    assign MSO = txsh_q[DW-1];

    always_comb begin
        for (int i = 0; i < NUM_CS; i++) begin
            SSn[i] = ~(ss_q && (cs_q == 3'(i)));
        end
    end

    always_comb begin
        status             = '0;
        status[0]          = tx_empty;
        status[1]          = tx_full;
        status[2]          = rx_empty;
        status[3]          = rx_full;
        status[4]          = (state_q != IDLE);
        status[8 +: LW]    = tx_lvl;
        status[16 +: LW]   = rx_lvl;
    end

    always_comb begin
        PRDATA = 32'hDEAD_BEEF;
        case (sel)
            6'h00: PRDATA = rx_empty ? 32'd0 : 32'(rx_mem[rx_rp_q[FIFO_AW-1:0]]);
            6'h01: PRDATA = {30'd0, cfg_q};
            6'h02: PRDATA = status;
            6'h03: PRDATA = {21'd0, cs_q, 6'd0, ss_q, en_q};
            6'h04: PRDATA = {24'd0, pre_q};
            6'h05: PRDATA = {28'd0, im_q};
            6'h06: PRDATA = {28'd0, ris};
            6'h07: PRDATA = 32'd0;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (tick && edge_last) state_d = LAST;
            LAST:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (tx_push) tx_mem[tx_wp_q[FIFO_AW-1:0]] <= PWDATA[DW-1:0];
        if (rx_push) rx_mem[rx_wp_q[FIFO_AW-1:0]] <= rxsh_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
            cfg_q   <= '0;
            en_q    <= 1'b0;
            ss_q    <= 1'b0;
            cs_q    <= '0;
            pre_q   <= '0;
            im_q    <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + LW'(1);
            if (start)   tx_rp_q <= tx_rp_q + LW'(1);
            if (rx_push) rx_wp_q <= rx_wp_q + LW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + LW'(1);
            if (wr_en) begin
                case (sel)
                    6'h01: cfg_q <= PWDATA[1:0];
                    6'h03: begin
                        en_q <= PWDATA[0];
                        ss_q <= PWDATA[1];
                        cs_q <= PWDATA[10:8];
                    end
                    6'h04: pre_q <= PWDATA[7:0];
                    6'h05: im_q  <= PWDATA[3:0];
                    default: ;
                endcase
            end
            // Sticky flags: a set in the same cycle wins over an IC clear.
            done_q <= in_last | (done_q & ~(ic_wr & PWDATA[0]));
            ovr_q  <= (in_last & rx_full & ~rx_pop) | (ovr_q & ~(ic_wr & PWDATA[1]));
            ovf_q  <= (tx_push_req & tx_full & ~start) | (ovf_q & ~(ic_wr & PWDATA[3]));
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            edge_q   <= '0;
            sck_q    <= 1'b0;
            cpol_l_q <= 1'b0;
            cpha_l_q <= 1'b0;
            pre_l_q  <= '0;
            txsh_q   <= '0;
            rxsh_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start) begin
                    txsh_q   <= tx_mem[tx_rp_q[FIFO_AW-1:0]];
                    rxsh_q   <= '0;
                    cnt_q    <= '0;
                    edge_q   <= '0;
                    sck_q    <= cfg_q[0];
                    cpol_l_q <= cfg_q[0];
                    cpha_l_q <= cfg_q[1];
                    pre_l_q  <= pre_q;
                end
                SHIFT: if (tick) begin
                    cnt_q  <= '0;
                    sck_q  <= ~sck_q;
                    edge_q <= edge_q + EW'(1);
                    if (cpha_l_q ? ~leading : leading)
                        rxsh_q <= {rxsh_q[DW-2:0], MSI};
                    // CPHA=1 already presents the MSB, so its first leading edge does not shift.
                    if (cpha_l_q ? (leading && edge_q != '0) : ~leading)
                        txsh_q <= txsh_q << 1;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
